// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round controller.
package aes_pkg;

    localparam int unsigned AES_NUM_ROUNDS_128 = 10;
    localparam int unsigned ROUND_W            = 4;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StKey,
        StArk,
        StSubGo,
        StSubWait,
        StShift,
        StMix,
        StDone
    } ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Control handshake bundle between command logic, round controller and datapath.
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic               start;
    logic               busy;
    logic               done;
    logic               error;
    logic [ROUND_W-1:0] round;
    logic               load_en;
    logic               sub_start;
    logic               sub_done;
    logic               shift_en;
    logic               mix_en;
    logic               key_req;
    logic [ROUND_W-1:0] key_round;
    logic               key_ack;
    logic               ark_en;

    // The environment side: command logic plus datapath responders.
    modport master (
        output start, sub_done, key_ack,
        input  busy, done, error, round, load_en, sub_start, shift_en, mix_en,
        input  key_req, key_round, ark_en
    );

    // The controller side.
    modport slave (
        input  start, sub_done, key_ack,
        output busy, done, error, round, load_en, sub_start, shift_en, mix_en,
        output key_req, key_round, ark_en
    );

endinterface

// File: rtl/aes_watchdog.sv
// Saturating cycle watchdog: counts enabled cycles since the last clear.
module aes_watchdog #(
    parameter int unsigned LIMIT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // High during the enabled cycle that brings the count to LIMIT, so the owner acts on that edge.
    assign expired = enable && !clear && (count_q >= (MAX - 1'b1));

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: drives per-step enables and key/SubBytes handshakes; holds no data.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS  = AES_NUM_ROUNDS_128,
    parameter int unsigned SUB_TIMEOUT = 32  // must be at least 2
) (
    input  logic             clk,
    input  logic             rst,
    aes_round_ctrl_if.slave  bus
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

    ctrl_state_t        state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               error_q, error_d;
    logic               wd_clear, wd_enable, wd_expired;

    // A cycle where sub_done arrives never counts, so a simultaneous sub_done beats the timeout.
    assign wd_clear  = (state_q == StSubGo);
    assign wd_enable = (state_q == StSubWait) && !bus.sub_done;

    aes_watchdog #(
        .LIMIT (SUB_TIMEOUT)
    ) u_sub_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            round_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        error_d = error_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLoad;
                    round_d = '0;
                    error_d = 1'b0;
                end
            end
            StLoad: begin
                round_d = '0;
                state_d = StKey;
            end
            StKey: begin
                if (bus.key_ack) begin
                    state_d = StArk;
                end
            end
            StArk: begin
                if (round_q == LAST_ROUND) begin
                    state_d = StDone;
                end else begin
                    round_d = round_q + 1'b1;
                    state_d = StSubGo;
                end
            end
            StSubGo: begin
                state_d = StSubWait;
            end
            StSubWait: begin
                if (bus.sub_done) begin
                    state_d = StShift;
                end else if (wd_expired) begin
                    error_d = 1'b1;
                    round_d = '0;
                    state_d = StIdle;
                end
            end
            StShift: begin
                state_d = (round_q == LAST_ROUND) ? StKey : StMix;
            end
            StMix: begin
                state_d = StKey;
            end
            StDone: begin
                round_d = '0;
                state_d = StIdle;
            end
            default: begin
                round_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        bus.load_en   = 1'b0;
        bus.sub_start = 1'b0;
        bus.shift_en  = 1'b0;
        bus.mix_en    = 1'b0;
        bus.key_req   = 1'b0;
        bus.ark_en    = 1'b0;
        unique case (state_q)
            StIdle:    bus.busy      = 1'b0;
            StLoad:    bus.load_en   = 1'b1;
            StKey:     bus.key_req   = 1'b1;
            StArk:     bus.ark_en    = 1'b1;
            StSubGo:   bus.sub_start = 1'b1;
            StSubWait: bus.busy      = 1'b1;
            StShift:   bus.shift_en  = 1'b1;
            StMix:     bus.mix_en    = 1'b1;
            StDone:    bus.done      = 1'b1;
            default:   bus.busy      = 1'b0;
        endcase
    end

    assign bus.round     = round_q;
    assign bus.key_round = round_q;
    assign bus.error     = error_q;

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequences one AES-128 encryption over the shared round datapath: state register, byte-serial SubBytes unit, ShiftRows, MixColumns, AddRoundKey and the key-expansion unit.
- Accepts a start request and issues per-step enables and handshakes round by round. Signals done, or error if the SubBytes unit stalls.
- Sits between the top-level command logic and the datapath. It holds no data, only control.

Parameters:
- NUM_ROUNDS, 10, number of full rounds. The final round omits MixColumns.
- SUB_TIMEOUT, 32, maximum SUB_WAIT cycles before the error abort. Must be ≥ 2.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request to encrypt. Sampled only in IDLE.
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; ciphertext is valid in the state register
- error  out  1  sticky SubBytes timeout flag. Cleared by an accepted start.
- round  out  4  current round index, 0..NUM_ROUNDS
- load_en  out  1  load plaintext into the state register
- sub_start  out  1  one-cycle pulse that starts the 16-byte SubBytes pass
- sub_done  in  1  SubBytes pass complete; a single-cycle pulse is sufficient
- shift_en  out  1  apply ShiftRows
- mix_en  out  1  apply MixColumns
- key_req  out  1  request round key key_round. Held until acknowledged.
- key_round  out  4  equals round
- key_ack  in  1  round key valid this cycle
- ark_en  out  1  apply AddRoundKey

Behaviour:
- Reset (async, active-high): state=IDLE, round=0, error=0. All outputs are 0.
- All outputs are Moore-decoded from the registered state, round counter and error flag. There is no combinational path from input to output.
- States: IDLE, LOAD, KEY, ARK, SUB_GO, SUB_WAIT, SHIFT, MIX, DONE.
- IDLE:
  - start=1 → LOAD; error is cleared on the same edge.
  - start is ignored in every other state, including DONE.
- LOAD: load_en=1, round=0; always → KEY.
- KEY: key_req=1; stays in KEY until key_ack=1 → ARK. key_ack may arrive in the first KEY cycle.
- ARK: ark_en=1.
  - If round==NUM_ROUNDS → DONE.
  - Otherwise round++ and → SUB_GO.
- SUB_GO: sub_start=1 for exactly one cycle; clears the watchdog; → SUB_WAIT.
- SUB_WAIT:
  - sub_done=1 → SHIFT.
  - Otherwise the watchdog increments.
  - When the watchdog reaches SUB_TIMEOUT with no sub_done: error←1, round←0, → IDLE. done is not pulsed.
  - sub_done arriving in the same cycle the timeout is reached: sub_done wins and the block goes to SHIFT.
  - sub_done seen in any other state is ignored.
- SHIFT: shift_en=1.
  - If round==NUM_ROUNDS → KEY (MixColumns is skipped).
  - Otherwise → MIX.
- MIX: mix_en=1; → KEY.
- DONE: done=1 for one cycle; round←0; → IDLE.
- Latency, with key_ack in the first KEY cycle and sub_done in wait cycle S:
  - round 0: 3 cycles
  - rounds 1..NUM_ROUNDS-1: 5+S cycles each
  - last round: 4+S cycles
  - DONE: 1 cycle
- Reset mid-operation aborts immediately to IDLE. No done, no error.
- Widths: round and key_round are 4 bits. The watchdog is $clog2(SUB_TIMEOUT+1) bits and saturates, never wrapping.
- At most one of load_en, sub_start, shift_en, mix_en, ark_en, key_req is high in any cycle.

Decomposition:
- aes_pkg holds:
  - ctrl_state_t enum (the nine states)
  - AES_NUM_ROUNDS_128=10
  - ROUND_W=4
- One sub-module, aes_watchdog:
  - inputs: clear, enable
  - output: expired when the count reaches LIMIT
  - parameter: LIMIT
  - Instantiated for SUB_WAIT; reusable later for a key_ack timeout.

Test Plan:
- Nominal run: start pulse, key_ack tied high, sub_done in the 16th SUB_WAIT cycle.
  - done high exactly 213 cycles after the start-sampling edge.
  - 10 sub_start pulses, 10 shift_en, 9 mix_en, 11 ark_en, 1 load_en.
  - round sequence 0,1..10 observed at ARK.
- Key stall: key_ack delayed 3 cycles on every request → done at 213+33=246 cycles; key_req held continuously while waiting; key_round==round throughout.
- Timeout: sub_done never asserted in round 4, SUB_TIMEOUT=32.
  - error=1 and busy=0 exactly 32 cycles after round-4 SUB_WAIT entry.
  - no done pulse.
  - next start clears error and the run completes normally.
- Start while busy: start pulses in round 2 and in the DONE cycle → both ignored; exactly one done; only one load_en.
- Async reset: rst asserted mid-round 7 between clock edges → all outputs 0 immediately and round=0. After release, a new start completes in 213 cycles.
- Simultaneity: sub_done coincides with the watchdog limit (cycle 32) → SHIFT taken, error stays 0.
